a5_keystream_gen: RTL and testbench

Sequencing controller and A5/1 keystream generator. It clears and loads the three A5/1 shift registers (R1/R2/R3) from a 64-bit session key and a 22-bit frame number. It then runs the majority-clocked warm-up and delivers the keystream one bit at a time over a valid/ready handshake. It drives the load, clock-enable and serial-data inputs of the LFSRs, and feeds the downstream cipher XOR stage.

---
 rtl/a5_keystream_gen_if.sv | 35 +++
 rtl/a5_keystream_gen.sv | 209 ++++++++++++++++++++
 tb/tb_a5_keystream_gen.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/a5_keystream_gen_if.sv
// Session/keystream handshake bundle between the A5/1 sequencer and its user.
interface a5_keystream_gen_if;
    logic        start;
    logic [63:0] key;
    logic [21:0] frame;
    logic        busy;
    logic        ks_valid;
    logic        ks_ready;
    logic        ks_bit;
    logic        done;

    // Session requester and keystream consumer side
    modport master (
        output start,
        output key,
        output frame,
        output ks_ready,
        input  busy,
        input  ks_valid,
        input  ks_bit,
        input  done
    );

    // Keystream generator side
    modport slave (
        input  start,
        input  key,
        input  frame,
        input  ks_ready,
        output busy,
        output ks_valid,
        output ks_bit,
        output done
    );
endinterface

// File: rtl/a5_keystream_gen.sv
// A5/1 keystream generator: loads R1/R2/R3 from a 64-bit key and a 22-bit
// frame number, runs the majority-clocked warm-up, then streams keystream
// bits one per valid/ready handshake.
module a5_keystream_gen #(
    parameter int NUM_KS_BITS = 228,
    parameter int WARMUP      = 100
) (
    input  logic               clk,
    input  logic               reset_n,
    a5_keystream_gen_if.slave  bus
);

    // One counter serves the key, frame, warm-up and output phases, so it
    // must hold the largest of their lengths.
    localparam int CNT_MAX_KW = (WARMUP > 64) ? WARMUP : 64;
    localparam int CNT_MAX    = (NUM_KS_BITS > CNT_MAX_KW) ? NUM_KS_BITS : CNT_MAX_KW;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] KEY_LAST   = CNT_W'(63);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(21);
    localparam logic [CNT_W-1:0] WARM_LAST  = CNT_W'(WARMUP - 1);
    localparam logic [CNT_W-1:0] BITS_TOTAL = CNT_W'(NUM_KS_BITS);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEY,
        S_FRAME,
        S_WARM,
        S_PRIME,
        S_STREAM
    } state_t;

    state_t           state_q,    state_d;
    logic [18:0]      r1_q,       r1_d;
    logic [21:0]      r2_q,       r2_d;
    logic [22:0]      r3_q,       r3_d;
    logic [63:0]      key_sh_q,   key_sh_d;
    logic [21:0]      frame_sh_q, frame_sh_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic             ks_bit_q,   ks_bit_d;
    logic             ks_valid_q, ks_valid_d;
    logic             done_q,     done_d;

    logic             load_bit;
    logic [18:0]      load_r1;
    logic [21:0]      load_r2;
    logic [22:0]      load_r3;
    logic             maj;
    logic [18:0]      maj_r1;
    logic [21:0]      maj_r2;
    logic [22:0]      maj_r3;
    logic             maj_out;

    // Single LFSR steps: shift left, feedback of the taps XORed with d
    function automatic logic [18:0] step_r1(input logic [18:0] r, input logic d);
        return {r[17:0], r[13] ^ r[16] ^ r[17] ^ r[18] ^ d};
    endfunction

    function automatic logic [21:0] step_r2(input logic [21:0] r, input logic d);
        return {r[20:0], r[20] ^ r[21] ^ d};
    endfunction

    function automatic logic [22:0] step_r3(input logic [22:0] r, input logic d);
        return {r[21:0], r[7] ^ r[20] ^ r[21] ^ r[22] ^ d};
    endfunction

    // Candidate register values for the load phases and for a majority step
    always_comb begin
        load_bit = (state_q == S_KEY) ? key_sh_q[cnt_q[5:0]] : frame_sh_q[cnt_q[4:0]];
        load_r1  = step_r1(r1_q, load_bit);
        load_r2  = step_r2(r2_q, load_bit);
        load_r3  = step_r3(r3_q, load_bit);

        maj    = (r1_q[8] & r2_q[10]) | (r1_q[8] & r3_q[10]) | (r2_q[10] & r3_q[10]);
        maj_r1 = (r1_q[8]  == maj) ? step_r1(r1_q, 1'b0) : r1_q;
        maj_r2 = (r2_q[10] == maj) ? step_r2(r2_q, 1'b0) : r2_q;
        maj_r3 = (r3_q[10] == maj) ? step_r3(r3_q, 1'b0) : r3_q;

        maj_out = maj_r1[18] ^ maj_r2[21] ^ maj_r3[22];
    end

    // Session sequencer: next-state, register updates and output bit
    always_comb begin
        state_d    = state_q;
        r1_d       = r1_q;
        r2_d       = r2_q;
        r3_d       = r3_q;
        key_sh_d   = key_sh_q;
        frame_sh_d = frame_sh_q;
        cnt_d      = cnt_q;
        ks_bit_d   = ks_bit_q;
        ks_valid_d = ks_valid_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    r1_d       = '0;
                    r2_d       = '0;
                    r3_d       = '0;
                    key_sh_d   = bus.key;
                    frame_sh_d = bus.frame;
                    cnt_d      = '0;
                    state_d    = S_KEY;
                end
            end

            S_KEY: begin
                r1_d = load_r1;
                r2_d = load_r2;
                r3_d = load_r3;
                if (cnt_q == KEY_LAST) begin
                    cnt_d   = '0;
                    state_d = S_FRAME;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            S_FRAME: begin
                r1_d = load_r1;
                r2_d = load_r2;
                r3_d = load_r3;
                if (cnt_q == FRAME_LAST) begin
                    cnt_d   = '0;
                    state_d = S_WARM;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            S_WARM: begin
                r1_d = maj_r1;
                r2_d = maj_r2;
                r3_d = maj_r3;
                if (cnt_q == WARM_LAST) begin
                    cnt_d   = '0;
                    state_d = S_PRIME;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            S_PRIME: begin
                r1_d       = maj_r1;
                r2_d       = maj_r2;
                r3_d       = maj_r3;
                ks_bit_d   = maj_out;
                ks_valid_d = 1'b1;
                cnt_d      = CNT_ONE;
                state_d    = S_STREAM;
            end

            S_STREAM: begin
                if (ks_valid_q && bus.ks_ready) begin
                    if (cnt_q < BITS_TOTAL) begin
                        r1_d     = maj_r1;
                        r2_d     = maj_r2;
                        r3_d     = maj_r3;
                        ks_bit_d = maj_out;
                        cnt_d    = cnt_q + CNT_ONE;
                    end else begin
                        ks_valid_d = 1'b0;
                        done_d     = 1'b1;
                        state_d    = S_IDLE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath flops; reset aborts any session without a done pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            r1_q       <= '0;
            r2_q       <= '0;
            r3_q       <= '0;
            key_sh_q   <= '0;
            frame_sh_q <= '0;
            cnt_q      <= '0;
            ks_bit_q   <= 1'b0;
            ks_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            r1_q       <= r1_d;
            r2_q       <= r2_d;
            r3_q       <= r3_d;
            key_sh_q   <= key_sh_d;
            frame_sh_q <= frame_sh_d;
            cnt_q      <= cnt_d;
            ks_bit_q   <= ks_bit_d;
            ks_valid_q <= ks_valid_d;
            done_q     <= done_d;
        end
    end

    assign bus.busy     = (state_q != S_IDLE);
    assign bus.ks_valid = ks_valid_q;
    assign bus.ks_bit   = ks_bit_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_a5_keystream_gen.sv
// Self-checking bench for a5_keystream_gen: reference A5/1 model feeding a
// scoreboard queue, a table of sessions, and hand-written corner sequences.
module tb_a5_keystream_gen;

    localparam int NUM_BITS = 228;
    localparam int WARM     = 100;
    localparam int TIMEOUT  = 4000;

    logic clk;
    logic reset_n;

    a5_keystream_gen_if bus ();

    a5_keystream_gen #(
        .NUM_KS_BITS (NUM_BITS),
        .WARMUP      (WARM)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [63:0] key;
        logic [21:0] frame;
        int          readyPct;
        bit          glitch;
        bit          checkBytes;
        int          expFirstValid;
        int          expHandshakes;
        int          expDoneEdge;
    } sessionVec_t;

    int   checks;
    int   failures;
    logic expQ[$];

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Absolute time limit so the run always ends
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic [63:0] k, input logic [21:0] f);
        bus.start = st;
        bus.key   = k;
        bus.frame = f;
    endtask

    // Reference A5/1: standard load-then-XOR formulation with tap masks
    function automatic logic [NUM_BITS-1:0] modelStream(input logic [63:0] k, input logic [21:0] f);
        logic [18:0]         a;
        logic [21:0]         b;
        logic [22:0]         c;
        logic                m;
        logic                d;
        logic [NUM_BITS-1:0] o;
        a = '0;
        b = '0;
        c = '0;
        o = '0;
        for (int i = 0; i < 86; i++) begin
            if (i < 64) d = k[i];
            else        d = f[i-64];
            a = {a[17:0], ^(a & 19'h72000)};
            b = {b[20:0], ^(b & 22'h300000)};
            c = {c[21:0], ^(c & 23'h700080)};
            a[0] = a[0] ^ d;
            b[0] = b[0] ^ d;
            c[0] = c[0] ^ d;
        end
        for (int i = 0; i < WARM + NUM_BITS; i++) begin
            m = (a[8] & b[10]) | (a[8] & c[10]) | (b[10] & c[10]);
            if (a[8]  == m) a = {a[17:0], ^(a & 19'h72000)};
            if (b[10] == m) b = {b[20:0], ^(b & 22'h300000)};
            if (c[10] == m) c = {c[21:0], ^(c & 23'h700080)};
            if (i >= WARM) o[i-WARM] = a[18] ^ b[21] ^ c[22];
        end
        return o;
    endfunction

    // One full session: push expected bits, start, consume, check timing
    task automatic runSession(input sessionVec_t v, input int idx);
        logic [NUM_BITS-1:0] expBits;
        logic [NUM_BITS-1:0] gotBits;
        logic [7:0]          refBytes [15];
        logic [7:0]          packed8;
        logic                expBit;
        logic                held;
        logic                heldBit;
        int                  e;
        int                  hs;
        int                  firstValid;
        int                  doneEdge;
        int                  lastHsE;
        int                  bi;

        refBytes = '{8'h53, 8'h4E, 8'hAA, 8'h58, 8'h2F, 8'hE8, 8'h15, 8'h1A,
                     8'hB6, 8'hE1, 8'h85, 8'h5A, 8'h72, 8'h8C, 8'h00};
        expBits    = modelStream(v.key, v.frame);
        gotBits    = '0;
        held       = 1'b0;
        heldBit    = 1'b0;
        hs         = 0;
        firstValid = -1;
        doneEdge   = -1;
        lastHsE    = -1;

        for (int i = 0; i < NUM_BITS; i++) expQ.push_back(expBits[i]);

        @(negedge clk);
        applyStimulus(1'b1, v.key, v.frame);
        @(negedge clk);
        applyStimulus(1'b0, ~v.key, ~v.frame);
        e = 0;
        checkOutput($sformatf("s%0d busy_after_start", idx), 64'(bus.busy), 64'd1);

        while (e < TIMEOUT) begin
            applyStimulus(1'b0, bus.key, bus.frame);
            if (bus.ks_valid && firstValid < 0) firstValid = e;
            if (held) begin
                checkOutput($sformatf("s%0d ks_bit_stable e%0d", idx, e), 64'(bus.ks_bit), 64'(heldBit));
                held = 1'b0;
            end
            if (bus.done) begin
                doneEdge = e;
                break;
            end
            if (v.glitch && (e == 50 || e == 300)) applyStimulus(1'b1, v.key ^ 64'hA5A5_5A5A_0F0F_F0F0, v.frame ^ 22'h3FFFFF);
            bus.ks_ready = ($urandom_range(99) < v.readyPct);
            if (bus.ks_valid && bus.ks_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput($sformatf("s%0d scoreboard_underflow", idx), 64'(hs), 64'(NUM_BITS - 1));
                end else begin
                    expBit = expQ.pop_front();
                    checkOutput($sformatf("s%0d ks_bit[%0d]", idx, hs), 64'(bus.ks_bit), 64'(expBit));
                end
                if (hs < NUM_BITS) gotBits[hs] = bus.ks_bit;
                hs++;
                lastHsE = e;
                if (v.glitch && hs == NUM_BITS) applyStimulus(1'b1, ~v.key, v.frame);
            end else if (bus.ks_valid) begin
                held    = 1'b1;
                heldBit = bus.ks_bit;
            end
            @(negedge clk);
            e++;
        end
        applyStimulus(1'b0, v.key, v.frame);
        bus.ks_ready = 1'b0;

        checkOutput($sformatf("s%0d done_seen", idx), 64'(doneEdge >= 0), 64'd1);
        checkOutput($sformatf("s%0d first_valid_edge", idx), 64'(firstValid), 64'(v.expFirstValid));
        checkOutput($sformatf("s%0d handshakes", idx), 64'(hs), 64'(v.expHandshakes));
        if (v.expDoneEdge >= 0)
            checkOutput($sformatf("s%0d done_edge", idx), 64'(doneEdge), 64'(v.expDoneEdge));
        else
            checkOutput($sformatf("s%0d done_after_last_hs", idx), 64'(doneEdge), 64'(lastHsE + 1));
        checkOutput($sformatf("s%0d busy_at_done", idx), 64'(bus.busy), 64'd0);
        checkOutput($sformatf("s%0d scoreboard_empty", idx), 64'(expQ.size()), 64'd0);
        expQ.delete();

        if (v.checkBytes) begin
            for (int b = 0; b < 15; b++) begin
                packed8 = '0;
                for (int j = 0; j < 8; j++) begin
                    bi = b * 8 + j;
                    if (bi < 114) packed8[7-j] = gotBits[bi];
                end
                checkOutput($sformatf("s%0d known_byte[%0d]", idx, b), 64'(packed8), 64'(refBytes[b]));
            end
        end

        @(negedge clk);
        checkOutput($sformatf("s%0d done_one_cycle", idx), 64'(bus.done), 64'd0);
        repeat (3) @(negedge clk);
        checkOutput($sformatf("s%0d stays_idle", idx), 64'(bus.busy), 64'd0);
    endtask

    // Abort a streaming session with reset and confirm clean outputs
    task automatic midSessionReset();
        logic [NUM_BITS-1:0] expBits;
        logic                expBit;
        int                  e;
        int                  n;
        int                  doneCnt;

        expBits = modelStream(64'hEFCDAB8967452312, 22'h134);
        n       = 0;
        doneCnt = 0;
        @(negedge clk);
        applyStimulus(1'b1, 64'hEFCDAB8967452312, 22'h134);
        bus.ks_ready = 1'b1;
        @(negedge clk);
        applyStimulus(1'b0, 64'hEFCDAB8967452312, 22'h134);
        for (e = 0; e < 250; e++) begin
            if (bus.ks_valid) begin
                expBit = expBits[n];
                checkOutput($sformatf("mr ks_bit[%0d]", n), 64'(bus.ks_bit), 64'(expBit));
                n++;
            end
            @(negedge clk);
        end
        checkOutput("mr streaming_before_reset", 64'(bus.ks_valid), 64'd1);
        reset_n = 1'b0;
        #1;
        checkOutput("mr outputs_in_reset", 64'({bus.busy, bus.ks_valid, bus.ks_bit, bus.done}), 64'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.done) doneCnt++;
        end
        checkOutput("mr no_done_during_reset", 64'(doneCnt), 64'd0);
        checkOutput("mr ks_valid_in_reset", 64'(bus.ks_valid), 64'd0);
        reset_n      = 1'b1;
        bus.ks_ready = 1'b0;
        expQ.delete();
        repeat (2) @(negedge clk);
        checkOutput("mr idle_after_release", 64'({bus.busy, bus.done}), 64'd0);
    endtask

    // Main sequence: reset behaviour, table of sessions, corner cases
    initial begin
        sessionVec_t vecs [4];

        checks   = 0;
        failures = 0;

        vecs[0] = '{key: 64'hEFCDAB8967452312, frame: 22'h134,   readyPct: 100, glitch: 1'b0,
                    checkBytes: 1'b1, expFirstValid: 187, expHandshakes: NUM_BITS, expDoneEdge: 415};
        vecs[1] = '{key: 64'hEFCDAB8967452312, frame: 22'h134,   readyPct: 30,  glitch: 1'b0,
                    checkBytes: 1'b1, expFirstValid: 187, expHandshakes: NUM_BITS, expDoneEdge: -1};
        vecs[2] = '{key: 64'hEFCDAB8967452312, frame: 22'h134,   readyPct: 100, glitch: 1'b1,
                    checkBytes: 1'b1, expFirstValid: 187, expHandshakes: NUM_BITS, expDoneEdge: 415};
        vecs[3] = '{key: 64'h0123456789ABCDEF, frame: 22'h2A5A5, readyPct: 70,  glitch: 1'b0,
                    checkBytes: 1'b0, expFirstValid: 187, expHandshakes: NUM_BITS, expDoneEdge: -1};

        reset_n      = 1'b0;
        bus.ks_ready = 1'b0;
        applyStimulus(1'b0, '0, '0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput($sformatf("reset_outputs c%0d", i),
                        64'({bus.busy, bus.ks_valid, bus.ks_bit, bus.done}), 64'd0);
            applyStimulus(i[0] == 1'b0, 64'hEFCDAB8967452312, 22'h134);
        end
        @(negedge clk);
        applyStimulus(1'b0, '0, '0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("idle_after_reset_release", 64'({bus.busy, bus.ks_valid, bus.done}), 64'd0);

        for (int s = 0; s < 4; s++) begin
            $display("[TB] session %0d: readyPct=%0d glitch=%0d", s, vecs[s].readyPct, vecs[s].glitch);
            runSession(vecs[s], s);
        end

        $display("[TB] mid-session reset sequence");
        midSessionReset();
        runSession(vecs[0], 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
